float_to_fixed_sp: RTL and testbench

FLOAT_TO_FIXED_SP -- requirements
Module: float_to_fixed_sp

---
 rtl/fp_sp_pkg.sv | 46 ++++
 rtl/srl.sv | 22 ++
 rtl/float_to_fixed_sp.sv | 136 +++++++++++++
 tb/tb_float_to_fixed_sp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_sp_pkg.sv
// Shared IEEE-754 single-precision constants and pipeline bundles
// for the float/fixed converters.
package fp_sp_pkg;

  localparam int lp_EXP_W  = 8;
  localparam int lp_MANT_W = 23;
  localparam int lp_BIAS   = 127;

  localparam logic [31:0] lp_SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] lp_SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    CLS_ZERO_SMALL,
    CLS_NORMAL,
    CLS_NEG_MIN,
    CLS_OVERFLOW
  } cls_e;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic                 nan;
    logic                 nz;
    cls_e                 cls;
    logic [lp_MANT_W-1:0] mant;
    logic [4:0]           amt;
  } s1_t;

  typedef struct packed {
    logic        valid;
    logic        sign;
    logic        nan;
    logic        nz;
    cls_e        cls;
    logic [31:0] mag;
    logic        sticky;
  } s2_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
    logic        invalid;
    logic        inexact;
  } out_t;

endpackage

// File: rtl/srl.sv
// Combinational logical right shift that also reports
// whether any set bit fell off the low end.
module srl #(
  parameter int p_DATA_WIDTH = 32,
  localparam int lp_SHW = $clog2(p_DATA_WIDTH)
) (
  input  logic [p_DATA_WIDTH-1:0] i_INPUT,
  input  logic [lp_SHW-1:0]       i_SHIFT_AMOUNT,
  output logic [p_DATA_WIDTH-1:0] o_RESULT,
  output logic                    o_STICKY
);

  logic [p_DATA_WIDTH-1:0] mask_w;

  // shift and OR together the bits below the shift point
  always_comb begin
    mask_w   = ~({p_DATA_WIDTH{1'b1}} << i_SHIFT_AMOUNT);
    o_RESULT = i_INPUT >> i_SHIFT_AMOUNT;
    o_STICKY = |(i_INPUT & mask_w);
  end

endmodule

// File: rtl/float_to_fixed_sp.sv
// Three-stage IEEE-754 single to int32 converter,
// truncating, saturating, with invalid/inexact flags.
module float_to_fixed_sp
  import fp_sp_pkg::*;
#(
  parameter int p_WORD_WIDTH = 31
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_N,
  input  logic                     i_VALID,
  input  logic [31:0]              i_FLOAT_WORD,
  output logic                     o_VALID,
  output logic signed [p_WORD_WIDTH:0] o_FIXED_WORD,
  output logic                     o_INVALID,
  output logic                     o_INEXACT
);

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  out_t out_d, out_q;

  logic                 sign_w;
  logic [lp_EXP_W-1:0]  exp_w;
  logic [lp_MANT_W-1:0] mant_w;
  logic signed [8:0]    e_w;
  logic                 small_w;
  logic                 norm_w;
  logic                 negmin_w;

  assign sign_w   = i_FLOAT_WORD[31];
  assign exp_w    = i_FLOAT_WORD[30:23];
  assign mant_w   = i_FLOAT_WORD[22:0];
  assign e_w      = $signed({1'b0, exp_w})
                  - $signed(9'(lp_BIAS));
  assign small_w  = e_w[8];
  assign norm_w   = !e_w[8] && (e_w <= 9'sd30);
  assign negmin_w = sign_w && (e_w == 9'sd31)
                  && (mant_w == '0);

  // stage 1: unbias exponent, classify, precompute shift
  always_comb begin
    s1_d = '0;
    if (i_VALID) begin
      s1_d.valid = 1'b1;
      s1_d.sign  = sign_w;
      s1_d.mant  = mant_w;
      s1_d.nan   = (exp_w == '1) && (mant_w != '0);
      s1_d.nz    = (exp_w != '0) || (mant_w != '0);
      s1_d.amt   = 5'd31 - e_w[4:0];
      unique case (1'b1)
        small_w:  s1_d.cls = CLS_ZERO_SMALL;
        norm_w:   s1_d.cls = CLS_NORMAL;
        negmin_w: s1_d.cls = CLS_NEG_MIN;
        default:  s1_d.cls = CLS_OVERFLOW;
      endcase
    end
  end

  logic [31:0] m_w;
  logic [31:0] shr_w;
  logic        stk_w;

  assign m_w = {1'b1, s1_q.mant, 8'b0};

  srl #(
    .p_DATA_WIDTH (32)
  ) u_srl (
    .i_INPUT        (m_w),
    .i_SHIFT_AMOUNT (s1_q.amt),
    .o_RESULT       (shr_w),
    .o_STICKY       (stk_w)
  );

  // stage 2: align magnitude, keep sticky for NORMAL only
  always_comb begin
    s2_d = '0;
    if (s1_q.valid) begin
      s2_d.valid = 1'b1;
      s2_d.sign  = s1_q.sign;
      s2_d.nan   = s1_q.nan;
      s2_d.nz    = s1_q.nz;
      s2_d.cls   = s1_q.cls;
      if (s1_q.cls == CLS_NORMAL) begin
        s2_d.mag    = shr_w;
        s2_d.sticky = stk_w;
      end
    end
  end

  // stage 3: apply sign, saturate, raise flags
  always_comb begin
    out_d = '0;
    if (s2_q.valid) begin
      out_d.valid = 1'b1;
      unique case (s2_q.cls)
        CLS_ZERO_SMALL: begin
          out_d.inexact = s2_q.nz;
        end
        CLS_NORMAL: begin
          out_d.word    = s2_q.sign
                        ? (~s2_q.mag + 32'd1)
                        : s2_q.mag;
          out_d.inexact = s2_q.sticky;
        end
        CLS_NEG_MIN: begin
          out_d.word = lp_SAT_NEG;
        end
        CLS_OVERFLOW: begin
          out_d.invalid = 1'b1;
          out_d.word    = (s2_q.sign && !s2_q.nan)
                        ? lp_SAT_NEG
                        : lp_SAT_POS;
        end
      endcase
    end
  end

  // pipeline registers; reset flushes everything in flight
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

  assign o_VALID      = out_q.valid;
  assign o_FIXED_WORD = out_q.word;
  assign o_INVALID    = out_q.invalid;
  assign o_INEXACT    = out_q.inexact;

endmodule

// File: tb/tb_float_to_fixed_sp.sv
// Directed self-checking bench for float_to_fixed_sp:
// single conversions, back-to-back stream, reset flush.
module tb_float_to_fixed_sp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_valid;
  logic signed [31:0] out_word;
  logic        out_inv;
  logic        out_inx;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  float_to_fixed_sp #(
    .p_WORD_WIDTH (31)
  ) dut (
    .i_CLK        (clk),
    .i_RST_N      (rst_n),
    .i_VALID      (in_valid),
    .i_FLOAT_WORD (in_word),
    .o_VALID      (out_valid),
    .o_FIXED_WORD (out_word),
    .o_INVALID    (out_inv),
    .o_INEXACT    (out_inx)
  );

  localparam int NV = 15;

  logic [31:0] cv_in [NV] = '{
    32'h3F80_0000, 32'hC020_0000, 32'h3F00_0000,
    32'hCF00_0000, 32'h4F00_0000, 32'hFF80_0000,
    32'h7FC0_0000, 32'h8000_0000, 32'h0000_0001,
    32'h7F80_0000, 32'hFFC0_0000, 32'hCF00_0001,
    32'h4EFF_FFFF, 32'hBF80_0000, 32'h4049_0FDB
  };
  logic [31:0] cv_word [NV] = '{
    32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000,
    32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
    32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000,
    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
    32'h7FFF_FF80, 32'hFFFF_FFFF, 32'h0000_0003
  };
  logic cv_inv [NV] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0
  };
  logic cv_inx [NV] = '{
    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1
  };

  localparam int NB = 10;

  logic        bb_iv [NB] = '{
    1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
    1'b1, 1'b0, 1'b0, 1'b0, 1'b0
  };
  logic [31:0] bb_in [NB] = '{
    32'h4B00_0001, 32'hDEAD_BEEF, 32'h4EFF_FFFF,
    32'hDEAD_BEEF, 32'h3F80_0000, 32'hBF80_0000,
    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
    32'hDEAD_BEEF
  };
  logic        bb_ov [NB] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b0, 1'b1, 1'b1, 1'b0
  };
  logic [31:0] bb_ow [NB] = '{
    32'h0, 32'h0, 32'h0, 32'h0080_0001, 32'h0,
    32'h7FFF_FF80, 32'h0, 32'h0000_0001,
    32'hFFFF_FFFF, 32'h0
  };

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'h3F80_0000;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({out_valid, out_word, out_inv, out_inx}
        !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: v=%0b w=%h inv=%0b inx=%0b want all 0",
               out_valid, out_word, out_inv, out_inx);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if ({out_valid, out_word, out_inv, out_inx}
          !== 35'd0) begin
        tests_failed++;
        $display("FAIL reset_release[%0d]: v=%0b w=%h want all 0",
                 i, out_valid, out_word);
      end
    end
  endtask

  task automatic test_convert();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = cv_in[i];
      @(negedge clk);
      in_valid = 1'b0;
      in_word  = 32'h0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || out_word !== 32'h0) begin
        tests_failed++;
        $display("FAIL early_%h: v=%0b w=%h want v=0 w=0",
                 cv_in[i], out_valid, out_word);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_word !== cv_word[i]
          || out_inv !== cv_inv[i]
          || out_inx !== cv_inx[i]) begin
        tests_failed++;
        $display("FAIL conv_%h: v=%0b w=%h inv=%0b inx=%0b want v=1 w=%h inv=%0b inx=%0b",
                 cv_in[i], out_valid, out_word, out_inv,
                 out_inx, cv_word[i], cv_inv[i], cv_inx[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== bb_ov[k] || out_word !== bb_ow[k]
          || out_inv !== 1'b0 || out_inx !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: v=%0b w=%h inv=%0b inx=%0b want v=%0b w=%h inv=0 inx=0",
                 k, out_valid, out_word, out_inv, out_inx,
                 bb_ov[k], bb_ow[k]);
      end
      in_valid = bb_iv[k];
      in_word  = bb_in[k];
    end
    in_valid = 1'b0;
    in_word  = 32'h0;
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = 32'h3F80_0000;
    @(negedge clk);
    in_word  = 32'hC020_0000;
    @(negedge clk);
    in_word  = 32'h4F00_0000;
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_word  = 32'h0;
    #1;
    tests_run++;
    if ({out_valid, out_word, out_inv, out_inx}
        !== 35'd0) begin
      tests_failed++;
      $display("FAIL async_clear: v=%0b w=%h want all 0",
               out_valid, out_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if ({out_valid, out_word, out_inv, out_inx}
          !== 35'd0) begin
        tests_failed++;
        $display("FAIL flushed[%0d]: v=%0b w=%h want all 0",
                 i, out_valid, out_word);
      end
    end
    in_valid = 1'b1;
    in_word  = 32'h3F80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = 32'h0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_word !== 32'h1
        || out_inv !== 1'b0 || out_inx !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_flush: v=%0b w=%h want v=1 w=00000001",
               out_valid, out_word);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_word  = 32'h0;
    test_reset();
    test_convert();
    test_back_to_back();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
